// File: rtl/timing_mode_ctrl_pkg.sv
// Shared definitions for the timing configuration sequencer.
//   - Field widths of the eight timing parameters.
//   - Shadow register address map.
//   - timing_cfg_t: one complete parameter set.
//   - tmc_state_e: sequencer states.
package timing_pkg;

  localparam int HT_W = 12;  // h_total, h_size
  localparam int HS_W = 11;  // h_sync, h_start
  localparam int VT_W = 11;  // v_total, v_size
  localparam int VS_W = 10;  // v_sync, v_start

  localparam logic [2:0] ADDR_H_TOTAL = 3'd0;
  localparam logic [2:0] ADDR_H_SIZE  = 3'd1;
  localparam logic [2:0] ADDR_H_SYNC  = 3'd2;
  localparam logic [2:0] ADDR_H_START = 3'd3;
  localparam logic [2:0] ADDR_V_TOTAL = 3'd4;
  localparam logic [2:0] ADDR_V_SIZE  = 3'd5;
  localparam logic [2:0] ADDR_V_SYNC  = 3'd6;
  localparam logic [2:0] ADDR_V_START = 3'd7;

  typedef struct packed {
    logic [HT_W-1:0] h_total;
    logic [HT_W-1:0] h_size;
    logic [HS_W-1:0] h_sync;
    logic [HS_W-1:0] h_start;
    logic [VT_W-1:0] v_total;
    logic [VT_W-1:0] v_size;
    logic [VS_W-1:0] v_sync;
    logic [VS_W-1:0] v_start;
  } timing_cfg_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FRAME,
    HOLD,
    WAIT_LOCK
  } tmc_state_e;

endpackage

// File: rtl/timing_mode_ctrl_cfg_check.sv
// Combinational validator for a timing parameter set.
//   cfg_i   : candidate parameter set
//   valid_o : high when totals >= 2, sync widths fit inside the totals and
//             start+size does not exceed the total (sums computed one bit
//             wider than the total so they never wrap).
module timing_cfg_check
  import timing_pkg::*;
(
  input  timing_cfg_t cfg_i,
  output logic        valid_o
);

  localparam int HE_W = HT_W + 1;
  localparam int VE_W = VT_W + 1;

  logic [HE_W-1:0] h_end;
  logic [VE_W-1:0] v_end;

  always_comb begin
    h_end   = HE_W'(cfg_i.h_size) + HE_W'(cfg_i.h_start);
    v_end   = VE_W'(cfg_i.v_size) + VE_W'(cfg_i.v_start);
    valid_o = (cfg_i.h_total >= HT_W'(2))
           && (cfg_i.v_total >= VT_W'(2))
           && (HT_W'(cfg_i.h_sync) < cfg_i.h_total)
           && (VT_W'(cfg_i.v_sync) < cfg_i.v_total)
           && (h_end <= HE_W'(cfg_i.h_total))
           && (v_end <= VE_W'(cfg_i.v_total));
  end

endmodule

// File: rtl/timing_mode_ctrl.sv
// Configuration sequencer for the video timing generator.
// Ports:
//   clk, rst_n         : clock, synchronous active-low reset
//   wr_en/addr/data    : host writes into the shadow parameter set
//   commit             : request to apply the shadow set
//   err_clr            : clears sticky timeout_err / lock_err
//   synco              : generator sync bus {vsync,hsync,de}
//   tg_rst_n           : active-low reset to the generator
//   h_*/v_*            : active timing parameters
//   vs_reset           : constant VS_RESET
//   busy, locked, done : sequencer status (done is a 1-cycle pulse)
//   cfg_err            : 1-cycle pulse on a rejected commit
//   timeout_err        : sticky, no frame boundary while waiting to apply
//   lock_err           : sticky, no vsync after an apply
module timing_mode_ctrl
  import timing_pkg::*;
#(
  parameter int unsigned RST_CYCLES  = 16,
  parameter int unsigned TIMEOUT     = 2**22,
  parameter int unsigned DEF_H_TOTAL = 2200,
  parameter int unsigned DEF_H_SIZE  = 1920,
  parameter int unsigned DEF_H_SYNC  = 44,
  parameter int unsigned DEF_H_START = 192,
  parameter int unsigned DEF_V_TOTAL = 1125,
  parameter int unsigned DEF_V_SIZE  = 1080,
  parameter int unsigned DEF_V_SYNC  = 5,
  parameter int unsigned DEF_V_START = 41,
  parameter int unsigned VS_RESET    = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [2:0]      wr_addr,
  input  logic [11:0]     wr_data,
  input  logic            commit,
  input  logic            err_clr,
  input  logic [2:0]      synco,
  output logic            tg_rst_n,
  output logic [HT_W-1:0] h_total,
  output logic [HT_W-1:0] h_size,
  output logic [HS_W-1:0] h_sync,
  output logic [HS_W-1:0] h_start,
  output logic [VT_W-1:0] v_total,
  output logic [VT_W-1:0] v_size,
  output logic [VS_W-1:0] v_sync,
  output logic [VS_W-1:0] v_start,
  output logic [22:0]     vs_reset,
  output logic            busy,
  output logic            locked,
  output logic            done,
  output logic            cfg_err,
  output logic            timeout_err,
  output logic            lock_err
);

  localparam int TMR_W = $clog2(TIMEOUT) + 1;
  localparam int CNT_W = $clog2(RST_CYCLES) + 1;

  localparam timing_cfg_t DEF_CFG = '{
    h_total: HT_W'(DEF_H_TOTAL),
    h_size:  HT_W'(DEF_H_SIZE),
    h_sync:  HS_W'(DEF_H_SYNC),
    h_start: HS_W'(DEF_H_START),
    v_total: VT_W'(DEF_V_TOTAL),
    v_size:  VT_W'(DEF_V_SIZE),
    v_sync:  VS_W'(DEF_V_SYNC),
    v_start: VS_W'(DEF_V_START)
  };

  tmc_state_e  state_q, state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic        vs_q;
  timing_cfg_t shadow_q, shadow_d;
  timing_cfg_t snap_q, snap_d;
  timing_cfg_t pend_cfg_q, pend_cfg_d;
  timing_cfg_t active_q, active_d;
  logic        pend_q, pend_d;
  logic        tg_rst_n_q, tg_rst_n_d;
  logic        locked_q, locked_d;
  logic        done_q, done_d;
  logic        cfg_err_q, cfg_err_d;
  logic        tmo_err_q, tmo_err_d;
  logic        lock_err_q, lock_err_d;

  logic        shadow_valid;
  logic        vs_rise;
  logic        tmr_expired;
  logic        start_apply;
  logic        unused_ok;

  timing_cfg_check u_check (
    .cfg_i   (shadow_q),
    .valid_o (shadow_valid)
  );

  assign vs_rise     = synco[2] & ~vs_q;
  assign tmr_expired = (timer_q == TMR_W'(TIMEOUT - 1));
  assign unused_ok   = ^synco[1:0];

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    timer_d     = (timer_q == '1) ? timer_q : timer_q + 1'b1;
    shadow_d    = shadow_q;
    snap_d      = snap_q;
    pend_cfg_d  = pend_cfg_q;
    active_d    = active_q;
    pend_d      = pend_q;
    tg_rst_n_d  = tg_rst_n_q;
    locked_d    = locked_q;
    done_d      = 1'b0;
    cfg_err_d   = 1'b0;
    tmo_err_d   = tmo_err_q;
    lock_err_d  = lock_err_q;
    start_apply = 1'b0;

    if (wr_en) begin
      case (wr_addr)
        ADDR_H_TOTAL: shadow_d.h_total = wr_data[HT_W-1:0];
        ADDR_H_SIZE:  shadow_d.h_size  = wr_data[HT_W-1:0];
        ADDR_H_SYNC:  shadow_d.h_sync  = wr_data[HS_W-1:0];
        ADDR_H_START: shadow_d.h_start = wr_data[HS_W-1:0];
        ADDR_V_TOTAL: shadow_d.v_total = wr_data[VT_W-1:0];
        ADDR_V_SIZE:  shadow_d.v_size  = wr_data[VT_W-1:0];
        ADDR_V_SYNC:  shadow_d.v_sync  = wr_data[VS_W-1:0];
        ADDR_V_START: shadow_d.v_start = wr_data[VS_W-1:0];
      endcase
    end

    // Error sets below override this clear.
    if (err_clr) begin
      tmo_err_d  = 1'b0;
      lock_err_d = 1'b0;
    end

    if (commit && !shadow_valid) begin
      cfg_err_d = 1'b1;
    end

    // A valid commit while busy queues its snapshot behind the current apply.
    if (commit && shadow_valid && (state_q != IDLE)) begin
      pend_d     = 1'b1;
      pend_cfg_d = shadow_q;
    end

    case (state_q)
      IDLE: begin
        // A fresh commit supersedes a queued snapshot.
        if (commit && shadow_valid) begin
          snap_d      = shadow_q;
          start_apply = 1'b1;
        end else if (pend_q) begin
          snap_d      = pend_cfg_q;
          start_apply = 1'b1;
        end
        if (start_apply) begin
          pend_d  = 1'b0;
          timer_d = '0;
          state_d = WAIT_FRAME;
        end
      end
      WAIT_FRAME: begin
        if (vs_rise || tmr_expired) begin
          if (!vs_rise) begin
            tmo_err_d = 1'b1;
          end
          state_d    = HOLD;
          hold_cnt_d = '0;
          tg_rst_n_d = 1'b0;
          locked_d   = 1'b0;
          active_d   = snap_q;
        end
      end
      HOLD: begin
        hold_cnt_d = hold_cnt_q + 1'b1;
        if (hold_cnt_q == CNT_W'(RST_CYCLES - 1)) begin
          tg_rst_n_d = 1'b1;
          timer_d    = '0;
          state_d    = WAIT_LOCK;
        end
      end
      WAIT_LOCK: begin
        if (vs_rise) begin
          locked_d = 1'b1;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else if (tmr_expired) begin
          lock_err_d = 1'b1;
          state_d    = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= HOLD;
      hold_cnt_q <= '0;
      timer_q    <= '0;
      vs_q       <= 1'b0;
      shadow_q   <= DEF_CFG;
      snap_q     <= DEF_CFG;
      pend_cfg_q <= DEF_CFG;
      active_q   <= DEF_CFG;
      pend_q     <= 1'b0;
      tg_rst_n_q <= 1'b0;
      locked_q   <= 1'b0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
      tmo_err_q  <= 1'b0;
      lock_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      timer_q    <= timer_d;
      vs_q       <= synco[2];
      shadow_q   <= shadow_d;
      snap_q     <= snap_d;
      pend_cfg_q <= pend_cfg_d;
      active_q   <= active_d;
      pend_q     <= pend_d;
      tg_rst_n_q <= tg_rst_n_d;
      locked_q   <= locked_d;
      done_q     <= done_d;
      cfg_err_q  <= cfg_err_d;
      tmo_err_q  <= tmo_err_d;
      lock_err_q <= lock_err_d;
    end
  end

  assign tg_rst_n    = tg_rst_n_q;
  assign h_total     = active_q.h_total;
  assign h_size      = active_q.h_size;
  assign h_sync      = active_q.h_sync;
  assign h_start     = active_q.h_start;
  assign v_total     = active_q.v_total;
  assign v_size      = active_q.v_size;
  assign v_sync      = active_q.v_sync;
  assign v_start     = active_q.v_start;
  assign vs_reset    = 23'(VS_RESET);
  assign busy        = (state_q != IDLE);
  assign locked      = locked_q;
  assign done        = done_q;
  assign cfg_err     = cfg_err_q;
  assign timeout_err = tmo_err_q;
  assign lock_err    = lock_err_q;

endmodule

// File: tb/tb_timing_mode_ctrl.sv
module tb_timing_mode_ctrl;

  localparam int TMO  = 100;
  localparam int RSTC = 16;
  localparam int GP   = 30;   // frame period of the stand-in generator

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [11:0] wr_data = '0;
  logic        commit = 1'b0;
  logic        err_clr = 1'b0;
  logic [2:0]  synco = '0;
  logic        tg_rst_n;
  logic [11:0] h_total, h_size;
  logic [10:0] h_sync, h_start, v_total, v_size;
  logic [9:0]  v_sync, v_start;
  logic [22:0] vs_reset;
  logic        busy, locked, done, cfg_err, timeout_err, lock_err;
  logic [87:0] act_o;

  timing_mode_ctrl #(.RST_CYCLES(RSTC), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .err_clr(err_clr), .synco(synco), .tg_rst_n(tg_rst_n),
    .h_total(h_total), .h_size(h_size), .h_sync(h_sync), .h_start(h_start),
    .v_total(v_total), .v_size(v_size), .v_sync(v_sync), .v_start(v_start),
    .vs_reset(vs_reset), .busy(busy), .locked(locked), .done(done),
    .cfg_err(cfg_err), .timeout_err(timeout_err), .lock_err(lock_err)
  );

  assign act_o = {h_total, h_size, h_sync, h_start, v_total, v_size, v_sync, v_start};

  always #5 clk = ~clk;

  typedef struct { int ht, hsz, hsy, hst, vt, vsz, vsy, vst; } cfg_t;
  typedef struct { cfg_t c; bit ok; } vec_t;

  int    checks = 0;
  int    errors = 0;
  int    done_cnt = 0;
  bit    gen_en = 1'b0;
  int    gcnt = 0;
  time   vs_rise_t = 0;
  cfg_t  DEF, model_act;
  vec_t  vecs[13];

  // Stand-in generator: free-running frames while tg_rst_n is high.
  always @(negedge clk) begin
    logic prev;
    prev = synco[2];
    if (!gen_en || tg_rst_n !== 1'b1) begin
      gcnt  = 0;
      synco = 3'b000;
    end else begin
      gcnt  = (gcnt == GP - 1) ? 0 : gcnt + 1;
      synco = {gcnt >= GP - 3, gcnt < 4, gcnt >= 4};
    end
    if (synco[2] && !prev) vs_rise_t = $time;
  end

  always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  function automatic cfg_t mk(int ht, int hsz, int hsy, int hst, int vt, int vsz, int vsy, int vst);
    cfg_t c;
    c.ht = ht; c.hsz = hsz; c.hsy = hsy; c.hst = hst;
    c.vt = vt; c.vsz = vsz; c.vsy = vsy; c.vst = vst;
    return c;
  endfunction

  function automatic logic [87:0] pk(cfg_t c);
    return {12'(c.ht), 12'(c.hsz), 11'(c.hsy), 11'(c.hst),
            11'(c.vt), 11'(c.vsz), 10'(c.vsy), 10'(c.vst)};
  endfunction

  function automatic bit ref_valid(cfg_t c);
    return c.ht >= 2 && c.vt >= 2 && c.hsy < c.ht && c.vsy < c.vt &&
           (c.hst + c.hsz) <= c.ht && (c.vst + c.vsz) <= c.vt;
  endfunction

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic cfg_t rnd();
    cfg_t c;
    int   k;
    if ($urandom_range(0, 3) == 0) begin
      c = mk($urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(0, 2047),
             $urandom_range(0, 2047), $urandom_range(0, 2047), $urandom_range(0, 2047),
             $urandom_range(0, 1023), $urandom_range(0, 1023));
    end else begin
      c.ht  = $urandom_range(2, 4095);
      c.hsz = $urandom_range(0, c.ht);
      c.hst = $urandom_range(0, imin(2047, c.ht - c.hsz));
      c.hsy = $urandom_range(0, imin(2047, c.ht - 1));
      c.vt  = $urandom_range(2, 2047);
      c.vsz = $urandom_range(0, c.vt);
      c.vst = $urandom_range(0, imin(1023, c.vt - c.vsz));
      c.vsy = $urandom_range(0, imin(1023, c.vt - 1));
      k = $urandom_range(0, 3);
      if (k == 1) c.hst = imin(2047, c.ht - c.hsz);
      if (k == 2) c.vst = imin(1023, c.vt - c.vsz + 1);
      if (k == 3) c.hsy = imin(2047, c.ht);
    end
    return c;
  endfunction

  task automatic chk(input string nm, input logic [87:0] act, input logic [87:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic write_field(input int a, input int v, input int w);
    logic [11:0] junk;
    junk    = 12'($urandom);
    junk    = junk << w;   // garbage above the field width must be dropped
    wr_en   = 1'b1;
    wr_addr = 3'(a);
    wr_data = 12'(v) | junk;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic write_cfg(input cfg_t c);
    write_field(0, c.ht, 12);  write_field(1, c.hsz, 12);
    write_field(2, c.hsy, 11); write_field(3, c.hst, 11);
    write_field(4, c.vt, 11);  write_field(5, c.vsz, 11);
    write_field(6, c.vsy, 10); write_field(7, c.vst, 10);
  endtask

  task automatic do_commit();
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
  endtask

  task automatic wait_low(input cfg_t old, output bit ok, output bit same);
    int n;
    n = 0; same = 1'b1;
    while (tg_rst_n !== 1'b0 && n < 300) begin
      if (act_o !== pk(old)) same = 1'b0;
      n++;
      @(negedge clk);
    end
    ok = (tg_rst_n === 1'b0);
  endtask

  task automatic measure_low(input cfg_t e, output int n, output bit same);
    n = 0; same = 1'b1;
    while (tg_rst_n === 1'b0 && n < 200) begin
      if (act_o !== pk(e)) same = 1'b0;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_done(output bit ok);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 300) begin
      n++;
      @(negedge clk);
    end
    ok = (done === 1'b1);
  endtask

  task automatic apply_cfg(input cfg_t c, input bit ok, input string nm);
    cfg_t old;
    bit   got, same;
    int   n;
    old = model_act;
    write_cfg(c);
    do_commit();
    if (!ok) begin
      chk({nm, " cfg_err"}, 88'(cfg_err), 88'(1));
      chk({nm, " busy"}, 88'(busy), 88'(0));
      chk({nm, " outputs held"}, act_o, pk(old));
      @(negedge clk);
      chk({nm, " cfg_err width"}, 88'(cfg_err), 88'(0));
      chk({nm, " busy after reject"}, 88'(busy), 88'(0));
    end else begin
      chk({nm, " no cfg_err"}, 88'(cfg_err), 88'(0));
      chk({nm, " busy"}, 88'(busy), 88'(1));
      wait_low(old, got, same);
      chk({nm, " hold entered"}, 88'(got), 88'(1));
      chk({nm, " outputs before frame"}, 88'(same), 88'(1));
      chk({nm, " hold-entry outputs"}, act_o, pk(c));
      measure_low(c, n, same);
      chk({nm, " hold length"}, 88'(n), 88'(RSTC));
      chk({nm, " outputs during hold"}, 88'(same), 88'(1));
      wait_done(got);
      chk({nm, " done"}, 88'(got), 88'(1));
      chk({nm, " locked"}, 88'(locked), 88'(1));
      @(negedge clk);
      chk({nm, " done width"}, 88'(done), 88'(0));
      model_act = c;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    cfg_t c, a, b, d;
    bit   got, same;
    int   n, d0;

    DEF = mk(2200, 1920, 44, 192, 1125, 1080, 5, 41);
    model_act = DEF;
    vecs[0]  = '{DEF, 1'b1};
    vecs[1]  = '{mk(20, 12, 2, 10, 10, 6, 1, 2), 1'b0};
    vecs[2]  = '{mk(2, 0, 1, 0, 2, 0, 1, 0), 1'b1};
    vecs[3]  = '{mk(1, 0, 0, 0, 10, 0, 0, 0), 1'b0};
    vecs[4]  = '{mk(20, 0, 0, 0, 1, 0, 0, 0), 1'b0};
    vecs[5]  = '{mk(20, 12, 20, 4, 10, 6, 1, 2), 1'b0};
    vecs[6]  = '{mk(20, 12, 19, 4, 10, 6, 9, 2), 1'b1};
    vecs[7]  = '{mk(20, 12, 2, 8, 10, 6, 1, 4), 1'b1};
    vecs[8]  = '{mk(20, 12, 2, 4, 10, 6, 10, 2), 1'b0};
    vecs[9]  = '{mk(10, 6, 1, 2, 10, 6, 1, 5), 1'b0};
    vecs[10] = '{mk(4095, 4095, 0, 2047, 100, 0, 0, 0), 1'b0};
    vecs[11] = '{mk(100, 0, 0, 0, 2047, 2047, 0, 1023), 1'b0};
    vecs[12] = '{mk(4095, 2048, 2047, 2047, 2047, 1024, 1023, 1023), 1'b1};

    // Power-up
    gen_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset tg_rst_n", 88'(tg_rst_n), 88'(0));
    chk("reset busy", 88'(busy), 88'(1));
    chk("reset flags", 88'({locked, done, cfg_err, timeout_err, lock_err}), 88'(0));
    chk("reset outputs", act_o, pk(DEF));
    chk("vs_reset", 88'(vs_reset), 88'(0));
    rst_n = 1'b1;
    measure_low(DEF, n, same);
    chk("powerup hold length", 88'(n), 88'(RSTC));
    chk("powerup outputs", 88'(same), 88'(1));
    wait_done(got);
    chk("powerup done", 88'(got), 88'(1));
    chk("powerup locked", 88'(locked), 88'(1));
    chk("lock one cycle after vsync", 88'($time - vs_rise_t), 88'(10));
    @(negedge clk);
    chk("powerup done width", 88'(done), 88'(0));
    chk("powerup idle", 88'(busy), 88'(0));

    apply_cfg(mk(20, 12, 2, 4, 10, 6, 1, 2), 1'b1, "small set");

    foreach (vecs[i]) apply_cfg(vecs[i].c, vecs[i].ok, $sformatf("vec%0d", i));

    for (int i = 0; i < 24; i++) begin
      c = rnd();
      apply_cfg(c, ref_valid(c), $sformatf("rand%0d", i));
    end

    // Queued commit during HOLD
    a = mk(24, 16, 3, 4, 12, 8, 2, 2);
    b = mk(50, 40, 6, 8, 25, 20, 2, 4);
    d0 = done_cnt;
    write_cfg(a);
    do_commit();
    wait_low(model_act, got, same);
    chk("queue A hold", 88'(got), 88'(1));
    write_cfg(b);
    do_commit();
    chk("queue still in hold", 88'(tg_rst_n), 88'(0));
    chk("queue A snapshot kept", act_o, pk(a));
    wait_done(got);
    chk("queue A done", 88'(got), 88'(1));
    chk("queue A outputs", act_o, pk(a));
    @(negedge clk);
    wait_done(got);
    chk("queue B done", 88'(got), 88'(1));
    chk("queue B outputs", act_o, pk(b));
    repeat (150) @(negedge clk);
    chk("queue done count", 88'(done_cnt - d0), 88'(2));
    chk("queue idle", 88'(busy), 88'(0));
    model_act = b;

    // Timeouts with a silent generator
    gen_en = 1'b0;
    c = mk(30, 20, 3, 5, 12, 8, 2, 3);
    d0 = done_cnt;
    write_cfg(c);
    do_commit();
    n = 0;
    while (timeout_err !== 1'b1 && n < 300) begin n++; @(negedge clk); end
    chk("timeout_err latency", 88'(n), 88'(TMO));
    chk("timeout hold entered", 88'(tg_rst_n), 88'(0));
    chk("timeout outputs applied", act_o, pk(c));
    measure_low(c, n, same);
    chk("timeout hold length", 88'(n), 88'(RSTC));
    n = 0;
    while (lock_err !== 1'b1 && n < 300) begin n++; @(negedge clk); end
    chk("lock_err latency", 88'(n), 88'(TMO));
    chk("lock_err locked", 88'(locked), 88'(0));
    chk("lock_err idle", 88'(busy), 88'(0));
    repeat (5) @(negedge clk);
    chk("errors sticky", 88'({timeout_err, lock_err}), 88'(2'b11));
    chk("no done on lock_err", 88'(done_cnt - d0), 88'(0));
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr", 88'({timeout_err, lock_err}), 88'(0));
    model_act = c;
    gen_en = 1'b1;

    // Reset during HOLD with a queued commit
    c = mk(20, 12, 2, 8, 10, 6, 1, 4);
    d = mk(40, 30, 5, 6, 20, 10, 3, 4);
    write_cfg(c);
    do_commit();
    wait_low(model_act, got, same);
    chk("reset test hold", 88'(got), 88'(1));
    write_cfg(d);
    do_commit();
    d0 = done_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midreset outputs", act_o, pk(DEF));
    chk("midreset status", 88'({tg_rst_n, busy, locked}), 88'(3'b010));
    measure_low(DEF, n, same);
    chk("midreset hold length", 88'(n), 88'(RSTC));
    wait_done(got);
    chk("midreset lock", 88'(got), 88'(1));
    repeat (150) @(negedge clk);
    chk("pending discarded", 88'(done_cnt - d0), 88'(1));
    chk("midreset final outputs", act_o, pk(DEF));
    chk("midreset idle", 88'(busy), 88'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
